// File: rtl/zigzag_rle_block_decoder.sv
// Rebuilds an 8x8 block of quantized coefficients from (run, level) symbols
// and drains it in raster order. Input and output phases alternate on one buffer.
module zigzag_rle_block_decoder #(
    parameter int unsigned W      = 25,
    parameter int unsigned ZIGZAG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sym_valid,
    output logic         sym_ready,
    input  logic         sym_eob,
    input  logic [5:0]   sym_run,
    input  logic [W-1:0] sym_level,
    output logic         coef_valid,
    input  logic         coef_ready,
    output logic [W-1:0] coef_out,
    output logic [5:0]   coef_index,
    output logic         coef_last,
    output logic         blk_err
);
    localparam int unsigned NCOEF = 64;
    localparam int unsigned PW    = 7;

    // Scan position -> raster address (JPEG zigzag order).
    localparam logic [5:0] ZZ_TAB [NCOEF] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {FILL, DRAIN} state_t;

    state_t           state, state_d;
    logic [PW-1:0]    pos, pos_d;
    logic [5:0]       rd_idx, rd_idx_d;
    logic [NCOEF-1:0] mask, mask_d;
    logic             sym_ready_d, coef_valid_d, coef_last_d, blk_err_d;
    logic [W-1:0]     coef_out_d;
    logic [W-1:0]     coef_mem [NCOEF];

    logic [PW-1:0]    pos_sum;
    logic             wr_en;
    logic [5:0]       wr_addr;
    logic [W-1:0]     wr_data;
    logic [5:0]       rd_next;

    assign pos_sum    = pos + PW'(sym_run);
    assign wr_addr    = (ZIGZAG != 0) ? ZZ_TAB[pos_sum[5:0]] : pos_sum[5:0];
    assign wr_data    = (sym_level[W-2:0] == '0) ? '0 : sym_level;
    assign rd_next    = rd_idx + 6'd1;
    assign coef_index = rd_idx;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state;
        pos_d        = pos;
        rd_idx_d     = rd_idx;
        mask_d       = mask;
        sym_ready_d  = sym_ready;
        coef_valid_d = coef_valid;
        coef_out_d   = coef_out;
        coef_last_d  = coef_last;
        blk_err_d    = blk_err;
        wr_en        = 1'b0;

        case (state)
            FILL: begin
                sym_ready_d = 1'b1;
                if (sym_valid && sym_ready) begin
                    if (sym_eob) begin
                        state_d = DRAIN;
                    end else if (pos_sum > PW'(63)) begin
                        state_d   = DRAIN;
                        blk_err_d = 1'b1;
                    end else begin
                        wr_en           = 1'b1;
                        mask_d[wr_addr] = 1'b1;
                        pos_d           = pos_sum + PW'(1);
                        if (pos_sum == PW'(63)) state_d = DRAIN;
                    end
                end
                if (state_d == DRAIN) begin
                    // A closing write always lands on raster 63, so entry 0 is settled here.
                    rd_idx_d     = 6'd0;
                    sym_ready_d  = 1'b0;
                    coef_valid_d = 1'b1;
                    coef_last_d  = 1'b0;
                    coef_out_d   = mask[0] ? coef_mem[0] : '0;
                end
            end
            DRAIN: begin
                if (coef_valid && coef_ready) begin
                    rd_idx_d = rd_next;
                    if (coef_last) begin
                        state_d      = FILL;
                        pos_d        = '0;
                        mask_d       = '0;
                        blk_err_d    = 1'b0;
                        coef_valid_d = 1'b0;
                        sym_ready_d  = 1'b1;
                        coef_out_d   = '0;
                        coef_last_d  = 1'b0;
                    end else begin
                        coef_last_d = (rd_next == 6'd63);
                        coef_out_d  = mask[rd_next] ? coef_mem[rd_next] : '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            pos        <= '0;
            rd_idx     <= '0;
            mask       <= '0;
            sym_ready  <= 1'b0;
            coef_valid <= 1'b0;
            coef_out   <= '0;
            coef_last  <= 1'b0;
            blk_err    <= 1'b0;
        end else begin
            state      <= state_d;
            pos        <= pos_d;
            rd_idx     <= rd_idx_d;
            mask       <= mask_d;
            sym_ready  <= sym_ready_d;
            coef_valid <= coef_valid_d;
            coef_out   <= coef_out_d;
            coef_last  <= coef_last_d;
            blk_err    <= blk_err_d;
        end
    end

    // Coefficient storage; unwritten entries are masked to zero on read.
    always_ff @(posedge clk) begin
        if (wr_en) coef_mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_zigzag_rle_block_decoder.sv
// Directed bench for zigzag_rle_block_decoder: placement, overflow, backpressure, reset.
module tb_zigzag_rle_block_decoder;
    localparam int unsigned W = 25;

    logic         clk, rst;
    logic         sym_valid, sym_ready, sym_eob;
    logic [5:0]   sym_run;
    logic [W-1:0] sym_level;
    logic         coef_valid, coef_ready, coef_last, blk_err;
    logic [W-1:0] coef_out;
    logic [5:0]   coef_index;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_blk [64];
    logic [5:0]   zz [64];

    zigzag_rle_block_decoder #(.W(W), .ZIGZAG(1)) dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_eob(sym_eob),
        .sym_run(sym_run), .sym_level(sym_level),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_out(coef_out),
        .coef_index(coef_index), .coef_last(coef_last), .blk_err(blk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_blk[i] = '0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_sym(input logic eob, input logic [5:0] run, input logic [W-1:0] lvl);
        int n;
        n = 0;
        sym_valid = 1'b1; sym_eob = eob; sym_run = run; sym_level = lvl;
        while (!sym_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) chk("sym_ready_timeout", 32'(sym_ready), 32'd1);
        @(negedge clk);
        sym_valid = 1'b0; sym_eob = 1'b0;
    endtask

    task automatic drain(input logic exp_err, input bit stall);
        for (int i = 0; i < 64; i++) begin
            if (stall && i == 10) begin
                coef_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_index", 32'(coef_index), 32'd10);
                    chk("hold_out", 32'(coef_out), 32'(exp_blk[10]));
                    chk("hold_sym_ready", 32'(sym_ready), 32'd0);
                end
                coef_ready = 1'b1;
            end
            chk($sformatf("valid[%0d]", i), 32'(coef_valid), 32'd1);
            chk($sformatf("index[%0d]", i), 32'(coef_index), 32'(i));
            chk($sformatf("out[%0d]", i), 32'(coef_out), 32'(exp_blk[i]));
            chk($sformatf("last[%0d]", i), 32'(coef_last), 32'(i == 63));
            chk($sformatf("err[%0d]", i), 32'(blk_err), 32'(exp_err));
            chk($sformatf("sym_ready[%0d]", i), 32'(sym_ready), 32'd0);
            @(negedge clk);
        end
        chk("post_valid", 32'(coef_valid), 32'd0);
        chk("post_sym_ready", 32'(sym_ready), 32'd1);
        chk("post_err", 32'(blk_err), 32'd0);
    endtask

    initial begin
        zz = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
               12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
               35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
               58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
        rst = 1'b1; sym_valid = 1'b0; sym_eob = 1'b0; sym_run = '0; sym_level = '0;
        coef_ready = 1'b1;
        #2 rst = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_sym_ready", 32'(sym_ready), 32'd0);
        chk("rst_coef_valid", 32'(coef_valid), 32'd0);
        chk("rst_coef_out", 32'(coef_out), 32'd0);
        chk("rst_coef_index", 32'(coef_index), 32'd0);
        chk("rst_coef_last", 32'(coef_last), 32'd0);
        chk("rst_blk_err", 32'(blk_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_sym_ready", 32'(sym_ready), 32'd1);
        chk("rel_coef_valid", 32'(coef_valid), 32'd0);

        // DC only
        clear_exp();
        exp_blk[0] = 25'h0000064;
        send_sym(1'b0, 6'd0, 25'd100);
        send_sym(1'b1, 6'd0, 25'd0);
        drain(1'b0, 1'b0);

        // Zigzag placement: scan 2 lands on raster 8
        clear_exp();
        exp_blk[0] = 25'd5;
        exp_blk[8] = 25'h1000003;
        send_sym(1'b0, 6'd0, 25'd5);
        send_sym(1'b0, 6'd1, 25'h1000003);
        send_sym(1'b1, 6'd0, 25'd0);
        drain(1'b0, 1'b0);

        // Full block, implicit close, negative zero, backpressure at index 10
        clear_exp();
        for (int k = 1; k < 64; k++) exp_blk[zz[k]] = W'(k);
        send_sym(1'b0, 6'd0, 25'h1000000);
        for (int k = 1; k < 64; k++) send_sym(1'b0, 6'd0, W'(k));
        chk("fb_raster2", 32'(exp_blk[2]), 32'd5);
        chk("fb_valid_latency", 32'(coef_valid), 32'd1);
        drain(1'b0, 1'b1);

        // Overflow: pos=60 then run 5 is dropped
        clear_exp();
        exp_blk[54] = 25'd1;
        send_sym(1'b0, 6'd59, 25'd1);
        send_sym(1'b0, 6'd5, 25'd7);
        drain(1'b1, 1'b0);

        // Reset mid-DRAIN at index 30
        send_sym(1'b0, 6'd0, 25'd9);
        send_sym(1'b0, 6'd0, 25'd11);
        send_sym(1'b1, 6'd0, 25'd0);
        repeat (30) @(negedge clk);
        chk("mid_index", 32'(coef_index), 32'd30);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(coef_valid), 32'd0);
        chk("mid_rst_out", 32'(coef_out), 32'd0);
        chk("mid_rst_sym_ready", 32'(sym_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_sym_ready", 32'(sym_ready), 32'd1);
        chk("mid_rel_valid", 32'(coef_valid), 32'd0);
        clear_exp();
        exp_blk[0] = 25'd100;
        send_sym(1'b0, 6'd0, 25'd100);
        send_sym(1'b1, 6'd0, 25'd0);
        drain(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/zigzag_rle_block_decoder.md
Name: zigzag_rle_block_decoder

Overview:
- Decoder end of the entropy stage: consumes (run, level) symbols produced by the run-length/zigzag coder after rounding.
- Rebuilds each 8x8 block of 64 quantized coefficients and emits them in raster order to the unquantization stage.
- One instance per colour channel (Y, Cb, Cr).
- Single internal 64-entry block buffer; input and output phases alternate; no overlap.

Parameters:
- W, 25, coefficient width. Sign-magnitude format: bit W-1 is the sign, bits W-2:0 are the magnitude (same as the codebase's integer format).
- ZIGZAG, 1, 1 = de-zigzag into raster order. 0 = output in scan order (raster index = scan index).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sym_valid  in  1  symbol present
- sym_ready  out  1  decoder accepts a symbol this cycle
- sym_eob  in  1  symbol is End-Of-Block; sym_run and sym_level are ignored
- sym_run  in  6  number of zero coefficients preceding the level
- sym_level  in  W  nonzero coefficient, sign-magnitude
- coef_valid  out  1  coefficient present
- coef_ready  in  1  downstream accepts the coefficient
- coef_out  out  W  coefficient value
- coef_index  out  6  raster index (0..63) of coef_out
- coef_last  out  1  high with index 63
- blk_err  out  1  current block contained a position overflow

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state cleared:
  - state=FILL, pos=0, rd_idx=0, occupancy mask=0.
  - sym_ready=0 during reset; sym_ready=1 from the first cycle after rst deasserts.
  - coef_valid=0, coef_out=0, coef_index=0, coef_last=0, blk_err=0.
- States: FILL, DRAIN.
- FILL:
  - sym_ready=1, coef_valid=0.
  - A symbol is accepted on a rising edge with sym_valid & sym_ready.
  - Non-EOB symbol with pos+run <= 63:
    - Write level to buffer at raster address zz(pos+run); set its mask bit.
    - pos <= pos+run+1 (7-bit arithmetic).
    - A level with magnitude 0 is stored as all-zero (negative zero normalized).
  - Non-EOB symbol with pos+run > 63: symbol dropped, blk_err <= 1, block closes.
  - EOB symbol: block closes. Positions pos..63 read as zero.
  - Block also closes implicitly when pos reaches 64 after a write.
  - Block close: state <= DRAIN, rd_idx <= 0, sym_ready <= 0 on the same edge.
- DRAIN:
  - sym_ready=0. coef_valid=1 starting the cycle after the closing edge (latency 1 cycle).
  - coef_index=rd_idx. coef_out = buf[rd_idx] if mask[rd_idx] set, else 0. coef_last = (rd_idx==63).
  - On coef_valid & coef_ready: rd_idx <= rd_idx+1.
  - While coef_ready=0: coef_out, coef_index and coef_last held stable.
  - On the handshake with coef_last=1, all on the same edge:
    - state <= FILL, pos <= 0, mask <= 0, blk_err <= 0.
    - coef_valid <= 0, sym_ready <= 1.
    - A new block can start on the next cycle.
  - Throughput: 64 output beats per block, plus 1 cycle of bubble between blocks.
- blk_err is set in the same edge as the overflow, held through the whole DRAIN, and cleared at the start of the next FILL.
- zz(k) with ZIGZAG=1 is the standard JPEG zigzag-to-raster map:
  - 0->0, 1->1, 2->8, 3->16, 4->9, 5->2, 6->3, 7->10, 8->17, 9->24, ... 62->55, 63->63.
  - Implemented as a 64-entry constant table.
- Buffer contents are never read before their mask bit is set, so stale data from a previous block never appears.
- Reset mid-FILL or mid-DRAIN: the partial block is discarded, all state and outputs return to reset values, and no coefficient beat is emitted.

Test Plan:
- DC only: {run0, level 100}, then EOB -> 64 beats. Index 0 = 0x0000064, indices 1..63 = 0, coef_last only at index 63, blk_err=0.
- Zigzag placement: {0,+5}, {1,-3}, EOB -> raster 0 = 5, raster 8 = 0x1000003 (scan pos 2), all others 0.
- Full block, no EOB: 64 symbols {0, k} for k=0..63 -> implicit close after the 64th symbol. Raster 2 = 5, raster 16 = 3, raster 63 = 63. Negative-zero test: symbol k=0 sent as 0x1000000 reads back as 0.
- Overflow: reach pos=60, then send {run5, 7} -> symbol dropped, blk_err=1 throughout DRAIN, raster zz(60..63) = 0. blk_err=0 once the next block's FILL begins.
- Backpressure: coef_ready=0 for 3 cycles at index 10 -> coef_out and coef_index held at 10. sym_ready stays 0 until the last beat completes, then goes 1 the next cycle.
- Reset mid-DRAIN at index 30: rst=0 for 2 cycles -> coef_valid=0 immediately. After release, sym_ready=1, and a new DC-only block outputs correctly with no residue from the old block.
